// File: rtl/ccheck_pkg.sv
// Shared constants and the trace record layout for the CPU-to-checker trace channel.
package ccheck_pkg;

    localparam int DEF_DEPTH = 8;
    localparam int DEF_DW    = 32;
    localparam int DEF_CW    = 16;

    typedef struct packed {
        logic [DEF_DW-1:0] pc;
        logic [DEF_DW-1:0] rs_value;
        logic [DEF_DW-1:0] rt_value;
        logic [DEF_DW-1:0] rd_value;
        logic [DEF_CW-1:0] seq;
    } trace_rec_t;

endpackage

// File: rtl/ccheck_if.sv
// Writeback capture inputs plus the valid/ready trace channel toward the checker.
interface ccheck_if
    import ccheck_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int CW = DEF_CW
);
    logic          trace_en;
    logic          wb_valid;
    logic [DW-1:0] wb_pc;
    logic [DW-1:0] wb_rs_value;
    logic [DW-1:0] wb_rt_value;
    logic [DW-1:0] wb_rd_value;
    logic [DW-1:0] pc;
    logic [DW-1:0] rs_value;
    logic [DW-1:0] rt_value;
    logic [DW-1:0] rd_value;
    logic [CW-1:0] seq;
    logic          trace_valid;
    logic          trace_ready;
    logic          fifo_full;
    logic          overflow;
    logic [CW-1:0] drop_count;

    modport master (
        input  trace_en, wb_valid, wb_pc, wb_rs_value, wb_rt_value, wb_rd_value, trace_ready,
        output pc, rs_value, rt_value, rd_value, seq, trace_valid, fifo_full, overflow, drop_count
    );

    modport slave (
        output trace_en, wb_valid, wb_pc, wb_rs_value, wb_rt_value, wb_rd_value, trace_ready,
        input  pc, rs_value, rt_value, rd_value, seq, trace_valid, fifo_full, overflow, drop_count
    );
endinterface

// File: rtl/ccheck_fifo.sv
// Synchronous show-ahead FIFO; pointers carry one extra wrap bit to tell full from empty.
module ccheck_fifo
    import ccheck_pkg::*;
#(
    parameter int  DEPTH = DEF_DEPTH,
    parameter type rec_t = trace_rec_t
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  rec_t                     din,
    input  logic                     pop,
    output rec_t                     dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    rec_t           mem [DEPTH];
    rec_t           last;
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Keeps the outputs on the last delivered record once the FIFO runs empty.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last <= '0;
        end else if (pop) begin
            last <= mem[rd_ptr[AW-1:0]];
        end
    end

    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = empty ? last : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/ccheck_driver.sv
// Producer end of the CPU/checker channel: qualifies writeback pushes, tags sequence numbers,
// tracks drops and maps the FIFO head onto the valid/ready trace port.
module ccheck_driver
    import ccheck_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int DW    = DEF_DW,
    parameter int CW    = DEF_CW
) (
    input  logic     clk,
    input  logic     reset_n,
    ccheck_if.master bus
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    // Local record follows any DW/CW override; the package record fixes the default layout.
    typedef struct packed {
        logic [DW-1:0] pc;
        logic [DW-1:0] rs_value;
        logic [DW-1:0] rt_value;
        logic [DW-1:0] rd_value;
        logic [CW-1:0] seq;
    } rec_t;

    logic          attempt;
    logic          pop;
    logic          push_ok;
    logic          drop;
    rec_t          wr_rec;
    rec_t          head;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic [CW-1:0] seq_ctr;
    logic [CW-1:0] drop_cnt;
    logic          ovf;

    assign attempt = bus.trace_en && bus.wb_valid;
    assign pop     = !empty && bus.trace_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push_ok = attempt && (!full || pop);
    assign drop    = attempt && !push_ok;

    assign wr_rec = '{pc:       bus.wb_pc,
                      rs_value: bus.wb_rs_value,
                      rt_value: bus.wb_rt_value,
                      rd_value: bus.wb_rd_value,
                      seq:      seq_ctr};

    ccheck_fifo #(
        .DEPTH (DEPTH),
        .rec_t (rec_t)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_ok),
        .din     (wr_rec),
        .pop     (pop),
        .dout    (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    // Dropped records still consume a sequence number so the checker sees the gap.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            seq_ctr  <= '0;
            drop_cnt <= '0;
            ovf      <= 1'b0;
        end else begin
            if (attempt) seq_ctr <= seq_ctr + CW'(1);
            if (drop) begin
                ovf <= 1'b1;
                if (drop_cnt != '1) drop_cnt <= drop_cnt + CW'(1);
            end
        end
    end

    assign bus.pc          = head.pc;
    assign bus.rs_value    = head.rs_value;
    assign bus.rt_value    = head.rt_value;
    assign bus.rd_value    = head.rd_value;
    assign bus.seq         = head.seq;
    assign bus.trace_valid = (count != '0);
    assign bus.fifo_full   = (count == FULL_CNT);
    assign bus.overflow    = ovf;
    assign bus.drop_count  = drop_cnt;

endmodule

// File: tb/tb_ccheck_driver.sv
// Directed bench for ccheck_driver: a vector table for basic traffic plus hand sequences
// for overflow, full-with-pop, capture disable and reset during drain.
module tb_ccheck_driver;
    import ccheck_pkg::*;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    ccheck_if #(.DW(32), .CW(16)) bus ();

    ccheck_driver #(.DEPTH(8), .DW(32), .CW(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] ctl;     // {reset_n, trace_en, wb_valid, trace_ready}
        int         pc;
        int         rs;
        int         rt;
        int         rd;
        logic [2:0] eflg;    // {trace_valid, fifo_full, overflow}
        int         e_pc;
        int         e_rd;
        int         e_seq;
        int         e_drop;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(logic [3:0] ctl, int pc, int rs, int rt, int rd,
                                logic [2:0] eflg, int e_pc, int e_rd, int e_seq, int e_drop);
        vec_t v;
        v.ctl = ctl; v.pc = pc; v.rs = rs; v.rt = rt; v.rd = rd;
        v.eflg = eflg; v.e_pc = e_pc; v.e_rd = e_rd; v.e_seq = e_seq; v.e_drop = e_drop;
        return v;
    endfunction

    task automatic chk(string nm, longint act, longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(logic en, logic wv, int pcv, int rsv, int rtv, int rdv, logic rdy);
        bus.trace_en    = en;
        bus.wb_valid    = wv;
        bus.wb_pc       = pcv;
        bus.wb_rs_value = rsv;
        bus.wb_rt_value = rtv;
        bus.wb_rd_value = rdv;
        bus.trace_ready = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
        step();
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
        @(negedge clk);
        do_reset();

        // Reset state
        chk("rst_valid", bus.trace_valid, 0);
        chk("rst_pc", bus.pc, 0);
        chk("rst_rs", bus.rs_value, 0);
        chk("rst_rt", bus.rt_value, 0);
        chk("rst_rd", bus.rd_value, 0);
        chk("rst_seq", bus.seq, 0);
        chk("rst_full", bus.fifo_full, 0);
        chk("rst_ovf", bus.overflow, 0);
        chk("rst_drop", bus.drop_count, 0);

        // Expected columns describe outputs in the same cycle, before that cycle's edge.
        tbl[0]  = mk(4'b1111, 'h40, 5, 7, 12,   3'b000, 0, 0, 0, 0);
        tbl[1]  = mk(4'b1101, 0, 0, 0, 0,       3'b100, 'h40, 12, 0, 0);
        tbl[2]  = mk(4'b1101, 0, 0, 0, 0,       3'b000, 0, 0, 0, 0);
        tbl[3]  = mk(4'b0110, 'hdead, 0, 0, 0,  3'b000, 0, 0, 0, 0);
        tbl[4]  = mk(4'b1110, 'h100, 1, 1, 1,   3'b000, 0, 0, 0, 0);
        tbl[5]  = mk(4'b1110, 'h104, 2, 2, 2,   3'b100, 'h100, 1, 0, 0);
        tbl[6]  = mk(4'b1110, 'h108, 3, 3, 3,   3'b100, 'h100, 1, 0, 0);
        tbl[7]  = mk(4'b1100, 0, 0, 0, 0,       3'b100, 'h100, 1, 0, 0);
        tbl[8]  = mk(4'b1100, 0, 0, 0, 0,       3'b100, 'h100, 1, 0, 0);
        tbl[9]  = mk(4'b1100, 0, 0, 0, 0,       3'b100, 'h100, 1, 0, 0);
        tbl[10] = mk(4'b1101, 0, 0, 0, 0,       3'b100, 'h100, 1, 0, 0);
        tbl[11] = mk(4'b1101, 0, 0, 0, 0,       3'b100, 'h104, 2, 1, 0);
        tbl[12] = mk(4'b1101, 0, 0, 0, 0,       3'b100, 'h108, 3, 2, 0);
        tbl[13] = mk(4'b1101, 0, 0, 0, 0,       3'b000, 0, 0, 0, 0);
        tbl[14] = mk(4'b1011, 'h200, 9, 9, 9,   3'b000, 0, 0, 0, 0);
        tbl[15] = mk(4'b1101, 0, 0, 0, 0,       3'b000, 0, 0, 0, 0);

        for (int i = 0; i < 16; i++) begin
            reset_n = tbl[i].ctl[3];
            drive(tbl[i].ctl[2], tbl[i].ctl[1], tbl[i].pc, tbl[i].rs, tbl[i].rt, tbl[i].rd,
                  tbl[i].ctl[0]);
            chk($sformatf("vec%0d_valid", i), bus.trace_valid, tbl[i].eflg[2]);
            chk($sformatf("vec%0d_full", i), bus.fifo_full, tbl[i].eflg[1]);
            chk($sformatf("vec%0d_ovf", i), bus.overflow, tbl[i].eflg[0]);
            chk($sformatf("vec%0d_drop", i), bus.drop_count, tbl[i].e_drop);
            if (tbl[i].eflg[2]) begin
                chk($sformatf("vec%0d_pc", i), bus.pc, tbl[i].e_pc);
                chk($sformatf("vec%0d_rd", i), bus.rd_value, tbl[i].e_rd);
                chk($sformatf("vec%0d_seq", i), bus.seq, tbl[i].e_seq);
            end
            step();
        end
        reset_n = 1'b1;

        // Overflow: 10 pushes into 8 slots with no ready
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, 'h1000 + 4 * i, i, 100 + i, i, 1'b0);
            step();
        end
        drive(1'b1, 1'b0, 0, 0, 0, 0, 1'b0);
        chk("ovf_full", bus.fifo_full, 1);
        chk("ovf_drop", bus.drop_count, 2);
        chk("ovf_flag", bus.overflow, 1);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 0, 0, 0, 0, 1'b1);
            chk($sformatf("ovf_drain%0d_valid", i), bus.trace_valid, 1);
            chk($sformatf("ovf_drain%0d_seq", i), bus.seq, i);
            chk($sformatf("ovf_drain%0d_pc", i), bus.pc, 'h1000 + 4 * i);
            chk($sformatf("ovf_drain%0d_rs", i), bus.rs_value, i);
            chk($sformatf("ovf_drain%0d_rt", i), bus.rt_value, 100 + i);
            step();
        end
        chk("ovf_empty_valid", bus.trace_valid, 0);
        chk("ovf_empty_full", bus.fifo_full, 0);
        drive(1'b1, 1'b1, 'h2000, 0, 0, 0, 1'b1);
        step();
        drive(1'b1, 1'b0, 0, 0, 0, 0, 1'b1);
        chk("ovf_next_valid", bus.trace_valid, 1);
        chk("ovf_next_seq", bus.seq, 10);
        chk("ovf_next_pc", bus.pc, 'h2000);
        chk("ovf_sticky", bus.overflow, 1);
        chk("ovf_drop_hold", bus.drop_count, 2);
        step();
        chk("ovf_next_gone", bus.trace_valid, 0);

        // Full FIFO with a push and pop in the same cycle
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 'h3000 + 4 * i, 0, 0, i, 1'b0);
            step();
        end
        drive(1'b1, 1'b1, 'h3020, 0, 0, 8, 1'b1);
        chk("fp_full_before", bus.fifo_full, 1);
        chk("fp_head_seq", bus.seq, 0);
        step();
        drive(1'b1, 1'b0, 0, 0, 0, 0, 1'b0);
        chk("fp_full_after", bus.fifo_full, 1);
        chk("fp_no_drop", bus.drop_count, 0);
        chk("fp_no_ovf", bus.overflow, 0);
        for (int i = 1; i < 9; i++) begin
            drive(1'b1, 1'b0, 0, 0, 0, 0, 1'b1);
            chk($sformatf("fp_drain%0d_seq", i), bus.seq, i);
            chk($sformatf("fp_drain%0d_pc", i), bus.pc, 'h3000 + 4 * i);
            chk($sformatf("fp_drain%0d_rd", i), bus.rd_value, i);
            step();
        end
        chk("fp_empty", bus.trace_valid, 0);

        // Capture disabled while records drain
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 'h4000 + 4 * i, 0, 0, 0, 1'b0);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 'hbad, 0, 0, 0, 1'b0);
            step();
        end
        chk("en_drop", bus.drop_count, 0);
        chk("en_full", bus.fifo_full, 0);
        chk("en_head", bus.seq, 0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 'hbad, 0, 0, 0, 1'b1);
            chk($sformatf("en_drain%0d_valid", i), bus.trace_valid, 1);
            chk($sformatf("en_drain%0d_seq", i), bus.seq, i);
            chk($sformatf("en_drain%0d_pc", i), bus.pc, 'h4000 + 4 * i);
            step();
        end
        chk("en_drained", bus.trace_valid, 0);
        drive(1'b1, 1'b1, 'h5000, 0, 0, 0, 1'b1);
        step();
        drive(1'b1, 1'b0, 0, 0, 0, 0, 1'b1);
        chk("en_seq_frozen", bus.seq, 4);
        step();

        // Reset in the middle of a drain
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 'h5100 + 4 * i, 0, 0, 0, 1'b0);
            step();
        end
        drive(1'b1, 1'b0, 0, 0, 0, 0, 1'b1);
        chk("mid_pop_seq", bus.seq, 5);
        step();
        reset_n = 1'b0;
        chk("mid_pre_valid", bus.trace_valid, 1);
        chk("mid_pre_seq", bus.seq, 6);
        step();
        reset_n = 1'b1;
        drive(1'b1, 1'b0, 0, 0, 0, 0, 1'b1);
        chk("mid_valid", bus.trace_valid, 0);
        chk("mid_pc", bus.pc, 0);
        chk("mid_seq_out", bus.seq, 0);
        chk("mid_full", bus.fifo_full, 0);
        drive(1'b1, 1'b1, 'h6000, 0, 0, 0, 1'b1);
        step();
        drive(1'b1, 1'b0, 0, 0, 0, 0, 1'b1);
        chk("mid_restart_valid", bus.trace_valid, 1);
        chk("mid_restart_seq", bus.seq, 0);
        chk("mid_restart_pc", bus.pc, 'h6000);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
